atm_cash_dispenser: RTL and testbench
=====================================

// Module: atm_cash_dispenser
// PURPOSE
//  Downstream of the ATM control FSM: takes an accepted withdrawal amount and pays it out as notes.
//  Plans a greedy 200/100/50 note breakdown against on-board stock, then pulses the dispenser motor once per note.
//  Reports completion or an error code, and tracks per-denomination stock that the service port can refill.
// PARAMETERS
//  CNT_W       8   width of each stock/plan counter
//  INIT_STOCK  50  notes per denomination after reset
//  MAX_NOTES   40  max notes per request; planning beyond this -> ERR_MANY
//  GAP_CYCLES  4   idle cycles after each dispense pulse (motor settle), >=1
//  LOW_THRESH  5   low-cash alarm threshold (ATM_LOW_CASH_ALARM_EN only)
// PORTS
//  clk             in   1      clock
//  rst             in   1      synchronous active-low reset
//  req_valid       in   1      withdrawal request
//  req_ready       out  1      1 only in IDLE; accept when req_valid&&req_ready
//  req_amount      in   12     amount in currency units, same range as the FSM's withdraw_value
//  load_valid      in   1      service refill strobe
//  load_denom      in   2      0=50, 1=100, 2=200, 3=ignored
//  load_count      in   CNT_W  notes to add
//  dispense_pulse  out  1      one-cycle motor pulse, one per note
//  dispense_denom  out  2      denomination of the current pulse (same encoding)
//  done            out  1      one-cycle completion pulse
//  done_ok         out  1      valid with done: 1=paid in full
//  err_code        out  2      valid with done: 0 OK, 1 ERR_AMOUNT, 2 ERR_STOCK, 3 ERR_MANY
//  stock_50/100/200 out CNT_W  current stock, registered
//  low_cash        out  1      alarm; constant 0 when macro is off
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state=IDLE; all outputs 0 except req_ready=1; stocks=INIT_STOCK.
//    An in-flight payout is abandoned, and notes already pulsed stay deducted from the lost state.
//  - FSM IDLE->PLAN->DISPENSE->GAP->(DISPENSE|DONE)->IDLE; PLAN->DONE on error.
//  - IDLE, on accept: latch amount to rem. If amount==0 or amount%50!=0 -> DONE with ERR_AMOUNT, no pulses.
//  - PLAN, one note per cycle, in priority order:
//      rem>=200 && stock_200>plan_200 -> plan_200++, rem-=200
//      else rem>=100 && stock_100>plan_100 -> 100
//      else rem>=50 && stock_50>plan_50 -> 50
//      else rem==0 -> DISPENSE
//      else -> ERR_STOCK
//    If total planned notes would exceed MAX_NOTES -> ERR_MANY. Stock is untouched on any error.
//  - DISPENSE: emit one pulse for the largest denom with plan>0, decrement that plan and its stock in the same cycle, then go to GAP.
//  - GAP: wait GAP_CYCLES cycles, then DISPENSE if any plan>0, else DONE.
//  - DONE: done=1 for one cycle with done_ok/err_code, then IDLE. Latency = 1+notes+1 planning plus notes*(1+GAP_CYCLES) dispensing.
//  - Refill: load_valid is applied only in IDLE when no accept occurs the same cycle; otherwise it is dropped.
//    Add saturates at 2^CNT_W-1. load_denom==3 is a no-op.
//  - req_valid outside IDLE is ignored; the upstream FSM must hold the request until req_ready.
//  - Arithmetic: rem is 12-bit unsigned and never underflows because of the guard compares. Counters are CNT_W unsigned.
// CONFIGURATION
//  ATM_LOW_CASH_ALARM_EN defined: low_cash is registered, 1 when any stock < LOW_THRESH; it updates the cycle after a stock change.
//  Undefined: low_cash tied 0 and no threshold logic.
// STRUCTURE
//  Package atm_cash_pkg: denom encodings (DEN_50/100/200), note values, err_code constants, state enum.
//  Sub-module atm_cash_stock: three saturating CNT_W counters with refill add, per-denom decrement and init value.
// TESTING
//  1 reset, then req 350 -> plan 200+100+50; pulses with denom 2,1,0 spaced by GAP_CYCLES; done_ok=1; stocks 49/49/49.
//  2 req 0 and req 120 -> done 2 cycles after accept, err_code=1, no pulses, stocks unchanged.
//  3 stock_200=0, stock_100=1, stock_50=1, req 400 -> err_code=2, stocks unchanged.
//  4 MAX_NOTES=40, stock_200=0, stock_100=0, req 2500 (50 fifties) -> err_code=3.
//  5 stock_50 at 254, CNT_W=8: load_denom=0, load_count=10 -> saturates at 255; a load during DISPENSE is dropped.
//  6 rst low mid-DISPENSE after 1 pulse -> next cycle IDLE, req_ready=1, stocks=INIT_STOCK, no further pulses;
//    with macro, a stock below 5 raises low_cash.

Source files
------------

// File: rtl/atm_cash_pkg.sv
// Shared encodings for the ATM cash dispenser: denominations, note values,
// completion codes and the controller state type.
package atm_cash_pkg;

  localparam logic [1:0] DEN_50   = 2'd0;
  localparam logic [1:0] DEN_100  = 2'd1;
  localparam logic [1:0] DEN_200  = 2'd2;
  localparam logic [1:0] DEN_NONE = 2'd3;

  localparam logic [11:0] VAL_50  = 12'd50;
  localparam logic [11:0] VAL_100 = 12'd100;
  localparam logic [11:0] VAL_200 = 12'd200;

  localparam logic [1:0] ERR_OK     = 2'd0;
  localparam logic [1:0] ERR_AMOUNT = 2'd1;
  localparam logic [1:0] ERR_STOCK  = 2'd2;
  localparam logic [1:0] ERR_MANY   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PLAN     = 3'd1,
    ST_DISPENSE = 3'd2,
    ST_GAP      = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  function automatic logic [11:0] note_value(input logic [1:0] denom);
    case (denom)
      DEN_200: return VAL_200;
      DEN_100: return VAL_100;
      default: return VAL_50;
    endcase
  endfunction

endpackage

// File: rtl/atm_cash_stock.sv
// Per-denomination note stock: three CNT_W counters loaded with INIT_STOCK on
// reset, with a saturating refill add and a single-note decrement.
module atm_cash_stock
  import atm_cash_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int INIT_STOCK = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [1:0]       load_denom,
  input  logic [CNT_W-1:0] load_count,
  input  logic             dec_en,
  input  logic [1:0]       dec_denom,
  output logic [CNT_W-1:0] stock_50,
  output logic [CNT_W-1:0] stock_100,
  output logic [CNT_W-1:0] stock_200
);

  localparam logic [CNT_W-1:0] INIT_V = CNT_W'(INIT_STOCK);
  localparam logic [CNT_W-1:0] ONE_V  = CNT_W'(1);

  logic [CNT_W-1:0] s50_q, s50_d;
  logic [CNT_W-1:0] s100_q, s100_d;
  logic [CNT_W-1:0] s200_q, s200_d;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  // The planner never schedules more notes than are in stock; the floor at
  // zero only keeps a counter from wrapping if that ever breaks.
  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] a);
    return (a == '0) ? a : a - ONE_V;
  endfunction

  always_comb begin
    s50_d  = s50_q;
    s100_d = s100_q;
    s200_d = s200_q;
    if (load_en) begin
      case (load_denom)
        DEN_50:  s50_d  = sat_add(s50_q, load_count);
        DEN_100: s100_d = sat_add(s100_q, load_count);
        DEN_200: s200_d = sat_add(s200_q, load_count);
        default: ;
      endcase
    end
    if (dec_en) begin
      case (dec_denom)
        DEN_50:  s50_d  = sat_dec(s50_q);
        DEN_100: s100_d = sat_dec(s100_q);
        DEN_200: s200_d = sat_dec(s200_q);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s50_q  <= INIT_V;
      s100_q <= INIT_V;
      s200_q <= INIT_V;
    end else begin
      s50_q  <= s50_d;
      s100_q <= s100_d;
      s200_q <= s200_d;
    end
  end

  assign stock_50  = s50_q;
  assign stock_100 = s100_q;
  assign stock_200 = s200_q;

endmodule

// File: rtl/atm_cash_dispenser.sv
// Pays out an accepted withdrawal as a greedy 200/100/50 note plan, one motor
// pulse per note. Optional low-cash alarm: define ATM_LOW_CASH_ALARM_EN.
module atm_cash_dispenser
  import atm_cash_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int INIT_STOCK = 50,
  parameter int MAX_NOTES  = 40,
  parameter int GAP_CYCLES = 4
`ifdef ATM_LOW_CASH_ALARM_EN
  ,
  parameter int LOW_THRESH = 5
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [11:0]      req_amount,
  input  logic             load_valid,
  input  logic [1:0]       load_denom,
  input  logic [CNT_W-1:0] load_count,
  output logic             dispense_pulse,
  output logic [1:0]       dispense_denom,
  output logic             done,
  output logic             done_ok,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] stock_50,
  output logic [CNT_W-1:0] stock_100,
  output logic [CNT_W-1:0] stock_200,
  output logic             low_cash
);

  localparam int TOT_W = $clog2(MAX_NOTES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [TOT_W-1:0] MAX_N    = TOT_W'(MAX_NOTES);
  localparam logic [TOT_W-1:0] TOT_ONE  = TOT_W'(1);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Request handshake: a request transfers on a cycle where req_valid and
  // req_ready are both high; req_ready is high only while idle, and the
  // requester holds req_valid/req_amount stable until that transfer.

  state_e           state_q, state_d;
  logic [11:0]      rem_q, rem_d;
  logic [CNT_W-1:0] plan_50_q, plan_50_d;
  logic [CNT_W-1:0] plan_100_q, plan_100_d;
  logic [CNT_W-1:0] plan_200_q, plan_200_d;
  logic [TOT_W-1:0] total_q, total_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [1:0]       err_q, err_d;
  logic             bad_amt_q, bad_amt_d;

  logic             accept;
  logic             load_en;
  logic             dec_en;
  logic             pick_ok;
  logic [1:0]       pick_denom;
  logic [1:0]       disp_denom;
  logic             any_plan;

  assign accept = req_valid && (state_q == ST_IDLE);

  atm_cash_stock #(
    .CNT_W      (CNT_W),
    .INIT_STOCK (INIT_STOCK)
  ) u_stock (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_en),
    .load_denom (load_denom),
    .load_count (load_count),
    .dec_en     (dec_en),
    .dec_denom  (disp_denom),
    .stock_50   (stock_50),
    .stock_100  (stock_100),
    .stock_200  (stock_200)
  );

  // Next note to plan: largest denomination that still fits the remainder
  // and has stock beyond what is already earmarked.
  always_comb begin
    pick_ok    = 1'b1;
    pick_denom = DEN_200;
    if ((rem_q >= VAL_200) && (stock_200 > plan_200_q)) begin
      pick_denom = DEN_200;
    end else if ((rem_q >= VAL_100) && (stock_100 > plan_100_q)) begin
      pick_denom = DEN_100;
    end else if ((rem_q >= VAL_50) && (stock_50 > plan_50_q)) begin
      pick_denom = DEN_50;
    end else begin
      pick_ok = 1'b0;
    end
  end

  always_comb begin
    disp_denom = DEN_50;
    if (plan_200_q != '0) begin
      disp_denom = DEN_200;
    end else if (plan_100_q != '0) begin
      disp_denom = DEN_100;
    end
  end

  assign any_plan = (plan_200_q != '0) || (plan_100_q != '0) || (plan_50_q != '0);

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    plan_50_d  = plan_50_q;
    plan_100_d = plan_100_q;
    plan_200_d = plan_200_q;
    total_d    = total_q;
    gap_d      = gap_q;
    err_d      = err_q;
    bad_amt_d  = bad_amt_q;
    load_en    = 1'b0;
    dec_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_PLAN;
          rem_d      = req_amount;
          plan_50_d  = '0;
          plan_100_d = '0;
          plan_200_d = '0;
          total_d    = '0;
          err_d      = ERR_OK;
          bad_amt_d  = (req_amount == 12'd0) || ((req_amount % VAL_50) != 12'd0);
        end else if (load_valid && (load_denom != DEN_NONE)) begin
          load_en = 1'b1;
        end
      end

      ST_PLAN: begin
        if (bad_amt_q) begin
          err_d   = ERR_AMOUNT;
          state_d = ST_DONE;
        end else if (pick_ok) begin
          if (total_q == MAX_N) begin
            err_d   = ERR_MANY;
            state_d = ST_DONE;
          end else begin
            rem_d   = rem_q - note_value(pick_denom);
            total_d = total_q + TOT_ONE;
            case (pick_denom)
              DEN_200: plan_200_d = plan_200_q + CNT_ONE;
              DEN_100: plan_100_d = plan_100_q + CNT_ONE;
              default: plan_50_d  = plan_50_q + CNT_ONE;
            endcase
          end
        end else if (rem_q == 12'd0) begin
          state_d = ST_DISPENSE;
        end else begin
          err_d   = ERR_STOCK;
          state_d = ST_DONE;
        end
      end

      ST_DISPENSE: begin
        dec_en  = 1'b1;
        gap_d   = GAP_INIT;
        state_d = ST_GAP;
        case (disp_denom)
          DEN_200: plan_200_d = plan_200_q - CNT_ONE;
          DEN_100: plan_100_d = plan_100_q - CNT_ONE;
          default: plan_50_d  = plan_50_q - CNT_ONE;
        endcase
      end

      ST_GAP: begin
        if (gap_q <= GAP_ONE) begin
          state_d = any_plan ? ST_DISPENSE : ST_DONE;
        end else begin
          gap_d = gap_q - GAP_ONE;
        end
      end

      ST_DONE: begin
        // Drop any plan left behind by an error so the next request starts clean.
        plan_50_d  = '0;
        plan_100_d = '0;
        plan_200_d = '0;
        state_d    = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      plan_50_q  <= '0;
      plan_100_q <= '0;
      plan_200_q <= '0;
      total_q    <= '0;
      gap_q      <= '0;
      err_q      <= ERR_OK;
      bad_amt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      plan_50_q  <= plan_50_d;
      plan_100_q <= plan_100_d;
      plan_200_q <= plan_200_d;
      total_q    <= total_d;
      gap_q      <= gap_d;
      err_q      <= err_d;
      bad_amt_q  <= bad_amt_d;
    end
  end

  assign req_ready      = (state_q == ST_IDLE);
  assign dispense_pulse = (state_q == ST_DISPENSE);
  assign dispense_denom = dispense_pulse ? disp_denom : DEN_50;
  assign done           = (state_q == ST_DONE);
  assign done_ok        = done && (err_q == ERR_OK);
  assign err_code       = done ? err_q : ERR_OK;

`ifdef ATM_LOW_CASH_ALARM_EN
  localparam logic [CNT_W-1:0] LOW_V = CNT_W'(LOW_THRESH);

  logic low_q, low_d;

  assign low_d = (stock_50 < LOW_V) || (stock_100 < LOW_V) || (stock_200 < LOW_V);

  always_ff @(posedge clk) begin
    if (!rst) begin
      low_q <= 1'b0;
    end else begin
      low_q <= low_d;
    end
  end

  assign low_cash = low_q;
`else
  assign low_cash = 1'b0;
`endif

endmodule

// File: tb/tb_atm_cash_dispenser.sv
// Self-checking bench for atm_cash_dispenser: a transaction-level payout model
// predicts every cycle's outputs; directed scenarios plus randomized traffic.
module tb_atm_cash_dispenser;

  localparam int CNT_W      = 8;
  localparam int INIT_STOCK = 50;
  localparam int MAX_NOTES  = 40;
  localparam int GAP_CYCLES = 4;
  localparam int LOW_THRESH = 5;
  localparam int SAT        = (1 << CNT_W) - 1;
`ifdef ATM_LOW_CASH_ALARM_EN
  localparam bit LOW_EN = 1'b1;
`else
  localparam bit LOW_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [11:0]      req_amount;
  logic             load_valid;
  logic [1:0]       load_denom;
  logic [CNT_W-1:0] load_count;
  logic             dispense_pulse;
  logic [1:0]       dispense_denom;
  logic             done;
  logic             done_ok;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] stock_50;
  logic [CNT_W-1:0] stock_100;
  logic [CNT_W-1:0] stock_200;
  logic             low_cash;

  always #5 clk = ~clk;

  atm_cash_dispenser #(
    .CNT_W      (CNT_W),
    .INIT_STOCK (INIT_STOCK),
    .MAX_NOTES  (MAX_NOTES),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_amount     (req_amount),
    .load_valid     (load_valid),
    .load_denom     (load_denom),
    .load_count     (load_count),
    .dispense_pulse (dispense_pulse),
    .dispense_denom (dispense_denom),
    .done           (done),
    .done_ok        (done_ok),
    .err_code       (err_code),
    .stock_50       (stock_50),
    .stock_100      (stock_100),
    .stock_200      (stock_200),
    .low_cash       (low_cash)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // The model works per transaction: at acceptance it computes the note mix
  // with division/min, then lays out pulse times and the done time from the
  // latency rule (planning 1+n+1 cycles, each note 1+GAP_CYCLES cycles).
  int         m_stock[3];
  bit         m_busy;
  int         m_k;
  int         m_done_k;
  int         m_err;
  bit         m_low;
  int         exp_time_q[$];
  logic [1:0] exp_denom_q[$];
  bit         chk_en = 1'b0;
  bit         e_pulse, e_done;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_accept(input int amt);
    int c[3];
    int r, n, idx;
    m_busy = 1'b1;
    m_k    = 1;
    exp_time_q.delete();
    exp_denom_q.delete();
    if (amt == 0 || (amt % 50) != 0) begin
      m_err    = 1;
      m_done_k = 2;
      return;
    end
    c[2] = imin(amt / 200, m_stock[2]);
    r    = amt - 200 * c[2];
    c[1] = imin(r / 100, m_stock[1]);
    r    = r - 100 * c[1];
    c[0] = imin(r / 50, m_stock[0]);
    r    = r - 50 * c[0];
    n    = c[0] + c[1] + c[2];
    if (n > MAX_NOTES) begin
      m_err    = 3;
      m_done_k = MAX_NOTES + 2;
    end else if (r != 0) begin
      m_err    = 2;
      m_done_k = n + 2;
    end else begin
      m_err = 0;
      idx   = 0;
      for (int d = 2; d >= 0; d--) begin
        for (int j = 0; j < c[d]; j++) begin
          exp_time_q.push_back(n + 2 + idx * (1 + GAP_CYCLES));
          exp_denom_q.push_back(2'(d));
          idx++;
        end
      end
      m_done_k = n + 2 + n * (1 + GAP_CYCLES);
    end
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 3; d++) m_stock[d] = INIT_STOCK;
      m_busy = 1'b0;
      m_k = 0;
      m_done_k = 0;
      m_err = 0;
      m_low = 1'b0;
      exp_time_q.delete();
      exp_denom_q.delete();
    end else begin
      m_low = (m_stock[0] < LOW_THRESH) || (m_stock[1] < LOW_THRESH) || (m_stock[2] < LOW_THRESH);
      if (m_busy) begin
        if (exp_time_q.size() > 0 && exp_time_q[0] == m_k) begin
          m_stock[exp_denom_q[0]] = m_stock[exp_denom_q[0]] - 1;
          void'(exp_time_q.pop_front());
          void'(exp_denom_q.pop_front());
        end
        if (m_k == m_done_k) m_busy = 1'b0;
        else m_k++;
      end else if (req_valid) begin
        model_accept(int'(req_amount));
      end else if (load_valid && load_denom != 2'd3) begin
        m_stock[load_denom] = imin(m_stock[load_denom] + int'(load_count), SAT);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      e_pulse = m_busy && exp_time_q.size() > 0 && exp_time_q[0] == m_k;
      e_done  = m_busy && (m_k == m_done_k);
      check("req_ready", req_ready, !m_busy);
      check("dispense_pulse", dispense_pulse, e_pulse);
      if (e_pulse) check("dispense_denom", dispense_denom, exp_denom_q[0]);
      check("done", done, e_done);
      if (e_done) begin
        check("done_ok", done_ok, m_err == 0);
        check("err_code", err_code, m_err);
      end
      check("stock_50", stock_50, m_stock[0]);
      check("stock_100", stock_100, m_stock[1]);
      check("stock_200", stock_200, m_stock[2]);
      check("low_cash", low_cash, LOW_EN ? m_low : 1'b0);
    end
  end

  // ---------------- drivers ----------------
  task automatic rand_load();
    load_valid = 1'($urandom_range(0, 1));
    load_denom = 2'($urandom_range(0, 3));
    load_count = CNT_W'($urandom_range(0, 40));
  endtask

  task automatic do_load(input int denom, input int cnt);
    @(negedge clk);
    load_valid = 1'b1;
    load_denom = 2'(denom);
    load_count = CNT_W'(cnt);
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  // Returns done-cycle index k (edges after acceptance), pulse count, the
  // pulse denominations packed 2 bits each, and first/last pulse k.
  task automatic run_req(input int amt, input bit noisy, output logic [1:0] err,
                         output int npulse, output int lat, output int sig,
                         output int first_k, output int last_k);
    int cyc;
    bit got;
    @(negedge clk);
    req_amount = 12'(amt);
    req_valid  = 1'b1;
    if (noisy) rand_load(); else load_valid = 1'b0;
    cyc = 0;
    while (!req_ready && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    load_valid = 1'b0;
    lat = 1; got = 1'b0; npulse = 0; sig = 0; first_k = -1; last_k = -1; err = 2'd0;
    while (!got && lat < 600) begin
      if (dispense_pulse) begin
        npulse++;
        sig = sig * 4 + int'(dispense_denom);
        if (first_k < 0) first_k = lat;
        last_k = lat;
      end
      if (done) begin
        got = 1'b1;
        err = err_code;
      end else begin
        if (noisy) rand_load();
        @(negedge clk);
        lat++;
      end
    end
    load_valid = 1'b0;
    check("done_seen", got, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  logic [1:0] r_err;
  int r_np, r_lat, r_sig, r_fk, r_lk, seen;

  initial begin
    rst = 1'b0;
    req_valid = 1'b0;
    req_amount = '0;
    load_valid = 1'b0;
    load_denom = '0;
    load_count = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_ready", req_ready, 1'b1);
    check("rst_pulse", dispense_pulse, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err_code, 2'd0);
    check("rst_stock_200", stock_200, INIT_STOCK);
    rst = 1'b1;

    // 350 -> one note of each, largest first
    run_req(350, 1'b0, r_err, r_np, r_lat, r_sig, r_fk, r_lk);
    check("t1_err", r_err, 0);
    check("t1_pulses", r_np, 3);
    check("t1_order", r_sig, 36);
    check("t1_first_k", r_fk, 5);
    check("t1_last_k", r_lk, 15);
    check("t1_latency", r_lat, 20);
    check("t1_stock_50", stock_50, 49);
    check("t1_stock_100", stock_100, 49);
    check("t1_stock_200", stock_200, 49);

    // bad amounts
    run_req(0, 1'b0, r_err, r_np, r_lat, r_sig, r_fk, r_lk);
    check("t2a_err", r_err, 1);
    check("t2a_latency", r_lat, 2);
    check("t2a_pulses", r_np, 0);
    run_req(120, 1'b0, r_err, r_np, r_lat, r_sig, r_fk, r_lk);
    check("t2b_err", r_err, 1);
    check("t2b_latency", r_lat, 2);
    check("t2b_stock_100", stock_100, 49);

    // drain 200s, then exactly MAX_NOTES hundreds
    run_req(4000, 1'b0, r_err, r_np, r_lat, r_sig, r_fk, r_lk);
    run_req(4000, 1'b0, r_err, r_np, r_lat, r_sig, r_fk, r_lk);
    run_req(1800, 1'b0, r_err, r_np, r_lat, r_sig, r_fk, r_lk);
    check("drain_stock_200", stock_200, 0);
    run_req(4000, 1'b0, r_err, r_np, r_lat, r_sig, r_fk, r_lk);
    check("max_exact_err", r_err, 0);
    check("max_exact_pulses", r_np, 40);
    run_req(900, 1'b0, r_err, r_np, r_lat, r_sig, r_fk, r_lk);
    check("drain_stock_100", stock_100, 0);

    // too many notes
    run_req(2500, 1'b0, r_err, r_np, r_lat, r_sig, r_fk, r_lk);
    check("t4_err", r_err, 3);
    check("t4_latency", r_lat, 42);
    check("t4_pulses", r_np, 0);
    check("t4_stock_50", stock_50, 49);

    // insufficient stock: 200=0, 100=1, 50=1
    run_req(2000, 1'b0, r_err, r_np, r_lat, r_sig, r_fk, r_lk);
    run_req(400, 1'b0, r_err, r_np, r_lat, r_sig, r_fk, r_lk);
    do_load(1, 1);
    run_req(400, 1'b0, r_err, r_np, r_lat, r_sig, r_fk, r_lk);
    check("t3_err", r_err, 2);
    check("t3_done_ok", done_ok, 1'b0);
    check("t3_latency", r_lat, 4);
    check("t3_stock_50", stock_50, 1);
    check("t3_stock_100", stock_100, 1);

    // refill saturation, ignored denomination, loads dropped while busy
    do_load(0, 253);
    check("t5_stock_254", stock_50, 254);
    do_load(0, 10);
    check("t5_saturate", stock_50, 255);
    do_load(3, 5);
    check("t5_denom3", stock_100, 1);
    run_req(50, 1'b1, r_err, r_np, r_lat, r_sig, r_fk, r_lk);
    check("t5_busy_drop_50", stock_50, 254);
    check("t5_busy_drop_200", stock_200, 0);

    // reset in the middle of a payout
    @(negedge clk);
    req_amount = 12'd350;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    seen = 0;
    while (!dispense_pulse && seen < 100) begin
      @(negedge clk);
      seen++;
    end
    check("t6_first_pulse", dispense_pulse, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("t6_ready", req_ready, 1'b1);
    check("t6_stock_50", stock_50, INIT_STOCK);
    check("t6_stock_100", stock_100, INIT_STOCK);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (dispense_pulse) seen++;
    end
    check("t6_no_pulses", seen, 0);

    // randomized traffic
    for (int t = 0; t < 30; t++) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        rand_load();
      end
      if ($urandom_range(0, 9) == 0) run_req($urandom_range(0, 4095), 1'b1, r_err, r_np, r_lat, r_sig, r_fk, r_lk);
      else run_req(50 * $urandom_range(0, 60), 1'b1, r_err, r_np, r_lat, r_sig, r_fk, r_lk);
    end

    // final reset
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("end_ready", req_ready, 1'b1);
    check("end_stock_200", stock_200, INIT_STOCK);
    check("end_low", low_cash, 1'b0);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
